hamming_stream_encoder: RTL and testbench
=========================================

// Module: hamming_stream_encoder
// PURPOSE
//  Parametrised serial-in/serial-out Hamming encoder, successor to the fixed 15/11 serial chain.
//  Collects K data bits, encodes to an N-bit codeword (optional SECDED overall parity) and streams it out.
//  Valid/ready handshakes on both sides. Output is double-buffered, so input collection overlaps output shifting.
// PARAMETERS
//  R         4  parity bit count; N = 2^R-1 codeword bits, K = N-R data bits (legal 3..6)
//  EXTENDED  0  1: append overall even-parity bit, so NT = N+1 serial bits; 0: NT = N
// PORTS
//  clk        in   1    rising-edge clock, single domain
//  RST        in   1    synchronous reset, active-high
//  in_valid   in   1    in_bit valid this cycle
//  in_bit     in   1    serial data bit, data bit d0 first
//  in_ready   out  1    block accepts in_bit this cycle
//  out_valid  out  1    out_bit valid
//  out_bit    out  1    serial codeword bit, position 1 first
//  out_ready  in   1    sink accepts out_bit this cycle
//  out_first  out  1    out_bit is codeword position 1
//  out_last   out  1    out_bit is final bit (pos N, or overall parity if EXTENDED)
//  words_out  out  16   count of completed output codewords, wraps at 16'hFFFF->0
// BEHAVIOUR
//  Reset: in_ready=1, out_valid=0, out_bit=0, out_first=0, out_last=0, words_out=0.
//   Input counter and buffer-full flags are cleared; any partial word or held codeword is discarded.
//  Input FSM, states FILL and HOLD:
//   FILL: in_ready=1. Each in_valid&in_ready shifts in_bit into data reg and increments cnt.
//   FILL -> HOLD when the K-th bit is accepted and the output buffer cannot take the word that cycle.
//   HOLD: in_ready=0; on the first cycle the output buffer is free, transfer the word and return to FILL.
//  Encoding (combinational on the K-bit data reg, registered at transfer):
//   - Positions p=1..N. Parity bits sit at p = 1,2,4,..,2^(R-1).
//   - Data bits d0..d(K-1) fill the non-power-of-two positions in ascending order (d0 at p=3).
//   - Parity at p=2^i is the XOR of all positions q != p with bit i of q set (even parity).
//   - cw[p-1] = position p. If EXTENDED, cw[N] = XOR of cw[N-1:0].
//  Output FSM, states IDLE and SHIFT:
//   IDLE: out_valid=0. A transfer loads the cw shift reg and enters SHIFT.
//   SHIFT: out_valid=1. Each out_valid&out_ready advances one bit (LSB first).
//    out_first is high for bit index 0; out_last is high for index NT-1.
//    The handshake on out_last increments words_out.
//   Outputs are held stable while out_valid=1 and out_ready=0.
//  Timing:
//   - Accepting the K-th bit at edge t with the output in IDLE gives out_valid=1, out_first=1 at t+1 (latency 1).
//   - Output buffer is free when state is IDLE, or when SHIFT and the out_last handshake occurs that cycle.
//   - Simultaneous K-th input bit and out_last handshake: new word loaded at that edge. No bubble, out_valid stays 1.
//   - Sustained out_ready=1 and in_valid=1: throughput is one word per max(K, NT) cycles.
//  in_valid while in_ready=0: bit ignored, not queued. in_bit when in_valid=0 is don't-care.
//  RST asserted mid-word or mid-shift: all state is dropped at that edge; the next word starts from d0.
// TESTING
//  - R=4, E=0: data 11'h001 -> out_bit 1,1,1 then twelve 0s; out_first on bit 1, out_last on bit 15; words_out=1.
//  - R=4, E=1: data 11'h7FF -> sixteen 1s (cw 15'h7FFF, overall parity 1). Data 11'h000 -> sixteen 0s.
//  - R=3, E=0: d0..d3 = 1,1,0,1 -> cw 7'h55, serial 1,0,1,0,1,0,1.
//  - Back-pressure: hold out_ready=0 for 20 cycles mid-codeword while feeding the next word.
//   -> out_bit frozen; in_ready drops after the K-th bit; no bit lost or duplicated.
//  - Back-to-back, R=4, E=0: out_ready=1 and in_valid=1 continuous.
//   -> out_valid never drops between words after the first; words_out increments every 15 cycles.
//  - RST pulse after 5 of 11 bits, and again mid-shift -> all outputs at reset values;
//   the next 11 bits give a correct codeword.

Source files
------------

// File: rtl/hamming_stream_encoder.sv
// Serial-in / serial-out Hamming encoder with an optional SECDED overall parity bit.
// Data bits are collected LSB-first into a K-bit register. The finished word is encoded
// and handed to a double-buffered output shifter, which streams the codeword out
// position 1 first. Because of the double buffering, input collection overlaps output shifting.
module hamming_stream_encoder #(
  parameter int R        = 4,
  parameter bit EXTENDED = 1'b0
) (
  input  logic        clk,
  input  logic        RST,
  input  logic        in_valid,
  input  logic        in_bit,
  output logic        in_ready,
  output logic        out_valid,
  output logic        out_bit,
  input  logic        out_ready,
  output logic        out_first,
  output logic        out_last,
  output logic [15:0] words_out
);

  localparam int N     = (1 << R) - 1;
  localparam int K     = N - R;
  localparam int NT    = N + (EXTENDED ? 1 : 0);
  localparam int CNT_W = $clog2(K);
  localparam int IDX_W = $clog2(NT);

  localparam logic [0:0] FILL  = 1'b0;
  localparam logic [0:0] HOLD  = 1'b1;
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  // Place data bits at non-power-of-two positions, then derive each even-parity bit
  // from every position that has the matching index bit set.
  function automatic logic [NT-1:0] encode(input logic [K-1:0] data);
    logic [NT-1:0] cw;
    logic          par;
    int            j;
    cw = '0;
    j  = 0;
    for (int p = 1; p <= N; p++) begin
      if ((p & (p - 1)) != 0) begin
        cw[p-1] = data[j];
        j++;
      end
    end
    for (int i = 0; i < R; i++) begin
      par = 1'b0;
      for (int q = 1; q <= N; q++) begin
        if (((q >> i) & 1) != 0) par = par ^ cw[q-1];
      end
      cw[(1 << i) - 1] = par;
    end
    if (EXTENDED) cw[NT-1] = ^cw[N-1:0];
    return cw;
  endfunction

  logic [K-1:0]     data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [0:0]       in_state_q, in_state_d;

  logic [NT-1:0]    sr_q, sr_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [0:0]       out_state_q, out_state_d;
  logic [15:0]      words_q, words_d;

  logic             accept;
  logic             last_in;
  logic             out_free;
  logic             transfer;
  logic [K-1:0]     word_shifted;
  logic [K-1:0]     enc_src;
  logic [NT-1:0]    cw;

  assign in_ready     = (in_state_q == FILL);
  assign accept       = in_valid & in_ready;
  assign last_in      = accept & (cnt_q == CNT_W'(K - 1));
  assign word_shifted = {in_bit, data_q[K-1:1]};

  assign out_valid = (out_state_q == SHIFT);
  assign out_bit   = out_valid & sr_q[0];
  assign out_first = out_valid & (idx_q == '0);
  assign out_last  = out_valid & (idx_q == IDX_W'(NT - 1));
  assign words_out = words_q;

  // The output side can take a word when idle, or when its final bit leaves this cycle.
  assign out_free = (out_state_q == IDLE) | (out_ready & out_last);
  assign transfer = (last_in | (in_state_q == HOLD)) & out_free;

  // A word completing this cycle is encoded from the shifted value so it can load with no extra cycle.
  assign enc_src  = (in_state_q == HOLD) ? data_q : word_shifted;
  assign cw       = encode(enc_src);

  // Input FSM: shift bits in while filling, and park a full word until the shifter frees up.
  always_comb begin
    data_d     = data_q;
    cnt_d      = cnt_q;
    in_state_d = in_state_q;
    case (in_state_q)
      FILL: begin
        if (accept) begin
          data_d = word_shifted;
          if (cnt_q == CNT_W'(K - 1)) begin
            cnt_d = '0;
            if (!out_free) in_state_d = HOLD;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      HOLD: begin
        if (out_free) in_state_d = FILL;
      end
      default: in_state_d = FILL;
    endcase
  end

  // Output FSM: shift the codeword out LSB first, count finished words, and reload on transfer.
  always_comb begin
    sr_d        = sr_q;
    idx_d       = idx_q;
    out_state_d = out_state_q;
    words_d     = words_q;
    if (out_valid && out_ready) begin
      sr_d  = sr_q >> 1;
      idx_d = idx_q + IDX_W'(1);
      if (out_last) begin
        words_d     = words_q + 16'd1;
        out_state_d = IDLE;
      end
    end
    if (transfer) begin
      sr_d        = cw;
      idx_d       = '0;
      out_state_d = SHIFT;
    end
  end

  // State registers; reset throws away any partial or buffered word.
  always_ff @(posedge clk) begin
    if (RST) begin
      data_q      <= '0;
      cnt_q       <= '0;
      in_state_q  <= FILL;
      sr_q        <= '0;
      idx_q       <= '0;
      out_state_q <= IDLE;
      words_q     <= 16'd0;
    end else begin
      data_q      <= data_d;
      cnt_q       <= cnt_d;
      in_state_q  <= in_state_d;
      sr_q        <= sr_d;
      idx_q       <= idx_d;
      out_state_q <= out_state_d;
      words_q     <= words_d;
    end
  end

endmodule

// File: tb/tb_hamming_stream_encoder.sv
// Directed bench for hamming_stream_encoder. It uses three instances that share clock and reset:
// slot 0 is R=4 plain, slot 1 is R=4 extended, and slot 2 is R=3 plain.
// Every expected codeword below was worked out by hand from the position rules.
`timescale 1ns/1ps
module tb_hamming_stream_encoder;

  logic        clk = 1'b0;
  logic        RST;
  logic        inValid  [3];
  logic        inBit    [3];
  logic        outReady [3];
  logic        inReady  [3];
  logic        outValid [3];
  logic        outBit   [3];
  logic        outFirst [3];
  logic        outLast  [3];
  logic [15:0] wordsOut [3];

  int          testsRun    = 0;
  int          testsFailed = 0;
  int          cycleCnt    = 0;
  logic [63:0] rxWord;
  int          rxFlagErr;
  int          gapCount;
  bit          countGaps;
  int          stallErr;
  int          t1, t2, t3;

  // Free-running clock and a cycle counter used for throughput measurements.
  always #5 clk = ~clk;
  always @(posedge clk) cycleCnt++;

  hamming_stream_encoder #(.R(4), .EXTENDED(1'b0)) u_r4 (
    .clk(clk), .RST(RST),
    .in_valid(inValid[0]), .in_bit(inBit[0]), .in_ready(inReady[0]),
    .out_valid(outValid[0]), .out_bit(outBit[0]), .out_ready(outReady[0]),
    .out_first(outFirst[0]), .out_last(outLast[0]), .words_out(wordsOut[0])
  );

  hamming_stream_encoder #(.R(4), .EXTENDED(1'b1)) u_r4e (
    .clk(clk), .RST(RST),
    .in_valid(inValid[1]), .in_bit(inBit[1]), .in_ready(inReady[1]),
    .out_valid(outValid[1]), .out_bit(outBit[1]), .out_ready(outReady[1]),
    .out_first(outFirst[1]), .out_last(outLast[1]), .words_out(wordsOut[1])
  );

  hamming_stream_encoder #(.R(3), .EXTENDED(1'b0)) u_r3 (
    .clk(clk), .RST(RST),
    .in_valid(inValid[2]), .in_bit(inBit[2]), .in_ready(inReady[2]),
    .out_valid(outValid[2]), .out_bit(outBit[2]), .out_ready(outReady[2]),
    .out_first(outFirst[2]), .out_last(outLast[2]), .words_out(wordsOut[2])
  );

  // Single comparison point: count it, and report when the observed value differs.
  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Feed k data bits, d0 first, into one slot. Called and returns on a falling edge.
  task automatic applyStimulus(input int sel, input logic [63:0] data, input int k);
    int i = 0;
    int guard = 0;
    bit accepted;
    inValid[sel] = 1'b1;
    inBit[sel]   = data[0];
    while (i < k && guard < 400) begin
      accepted = inReady[sel];
      @(negedge clk);
      guard++;
      if (accepted) begin
        i++;
        if (i < k) inBit[sel] = data[i];
      end
    end
    inValid[sel] = 1'b0;
    checkOutput("txCount", 64'(i), 64'(k));
  endtask

  // Collect serial bits startIdx..stopIdx-1 into rxWord, and track the first/last flags.
  task automatic receiveWord(input int sel, input int startIdx, input int stopIdx, input int nt);
    int n = startIdx;
    int guard = 0;
    if (startIdx == 0) begin
      rxWord    = '0;
      rxFlagErr = 0;
    end
    outReady[sel] = 1'b1;
    while (n < stopIdx && guard < 400) begin
      if (outValid[sel]) begin
        rxWord[n] = outBit[sel];
        if (outFirst[sel] !== (n == 0)) rxFlagErr++;
        if (outLast[sel] !== (n == nt - 1)) rxFlagErr++;
        n++;
      end else if (countGaps) begin
        gapCount++;
      end
      @(negedge clk);
      guard++;
    end
    outReady[sel] = 1'b0;
    checkOutput("rxCount", 64'(n), 64'(stopIdx));
  endtask

  // One reset edge, released on the following falling edge.
  task automatic pulseReset();
    RST = 1'b1;
    @(negedge clk);
    RST = 1'b0;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput(tag, 64'({inReady[0], outValid[0], outBit[0], outFirst[0], outLast[0]}), 64'(5'b10000));
    checkOutput({tag, "Words"}, 64'(wordsOut[0]), 64'd0);
  endtask

  // Watchdog so a stuck handshake can never hang the run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: run did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main directed sequence.
  initial begin
    RST = 1'b1;
    for (int s = 0; s < 3; s++) begin
      inValid[s]  = 1'b0;
      inBit[s]    = 1'b0;
      outReady[s] = 1'b0;
    end
    rxWord    = '0;
    rxFlagErr = 0;
    gapCount  = 0;
    countGaps = 1'b0;
    stallErr  = 0;
    repeat (3) @(negedge clk);
    checkResetOutputs("resetState");
    RST = 1'b0;
    @(negedge clk);

    // Extended R=4: all ones gives sixteen ones, and all zeros gives sixteen zeros.
    applyStimulus(1, 64'h7FF, 11);
    receiveWord(1, 0, 16, 16);
    checkOutput("extOnes", rxWord, 64'hFFFF);
    checkOutput("extOnesFlags", 64'(rxFlagErr), 64'd0);
    applyStimulus(1, 64'h000, 11);
    receiveWord(1, 0, 16, 16);
    checkOutput("extZeros", rxWord, 64'h0);
    checkOutput("extWords", 64'(wordsOut[1]), 64'd2);

    // R=3: d0..d3 = 1,1,0,1 encodes to 7'h55.
    applyStimulus(2, 64'hB, 4);
    receiveWord(2, 0, 7, 7);
    checkOutput("r3Word", rxWord, 64'h55);
    checkOutput("r3Flags", 64'(rxFlagErr), 64'd0);
    checkOutput("r3Words", 64'(wordsOut[2]), 64'd1);

    // R=4 single word: data 1 gives positions 1..3 set; the output is valid one edge after the last bit.
    applyStimulus(0, 64'h001, 11);
    checkOutput("latency", 64'({outValid[0], outFirst[0]}), 64'(2'b11));
    receiveWord(0, 0, 15, 15);
    checkOutput("word001", rxWord, 64'h7);
    checkOutput("word001Flags", 64'(rxFlagErr), 64'd0);
    checkOutput("word001Count", 64'(wordsOut[0]), 64'd1);

    // Back-pressure: stall after four bits of 0x003 (cw 0x1E) while the next word 0x400 arrives.
    applyStimulus(0, 64'h003, 11);
    receiveWord(0, 0, 4, 15);
    checkOutput("bpBit4", 64'(outBit[0]), 64'd1);
    fork
      applyStimulus(0, 64'h400, 11);
      begin
        repeat (20) begin
          @(negedge clk);
          if (outBit[0] !== 1'b1 || outValid[0] !== 1'b1 || outFirst[0] !== 1'b0) stallErr++;
        end
      end
    join
    checkOutput("bpFrozen", 64'(stallErr), 64'd0);
    checkOutput("bpInReady", 64'(inReady[0]), 64'd0);
    receiveWord(0, 4, 15, 15);
    checkOutput("bpWordA", rxWord, 64'h1E);
    checkOutput("bpFlagsA", 64'(rxFlagErr), 64'd0);
    receiveWord(0, 0, 15, 15);
    checkOutput("bpWordB", rxWord, 64'h408B);
    checkOutput("bpWords", 64'(wordsOut[0]), 64'd3);

    // Back-to-back: continuous traffic in both directions, so one word leaves every 15 cycles.
    fork
      begin
        applyStimulus(0, 64'h010, 11);
        applyStimulus(0, 64'h002, 11);
        applyStimulus(0, 64'h400, 11);
      end
      begin
        receiveWord(0, 0, 15, 15);
        t1 = cycleCnt;
        checkOutput("b2bWord0", rxWord, 64'h181);
        countGaps = 1'b1;
        receiveWord(0, 0, 15, 15);
        t2 = cycleCnt;
        checkOutput("b2bWord1", rxWord, 64'h19);
        receiveWord(0, 0, 15, 15);
        t3 = cycleCnt;
        checkOutput("b2bWord2", rxWord, 64'h408B);
        checkOutput("b2bFlags", 64'(rxFlagErr), 64'd0);
        countGaps = 1'b0;
      end
    join
    checkOutput("b2bGaps", 64'(gapCount), 64'd0);
    checkOutput("b2bPeriod1", 64'(t2 - t1), 64'd15);
    checkOutput("b2bPeriod2", 64'(t3 - t2), 64'd15);
    checkOutput("b2bWords", 64'(wordsOut[0]), 64'd6);

    // Reset after a partial word, then again mid-shift; afterwards, a clean word must come out.
    applyStimulus(0, 64'h7FF, 5);
    pulseReset();
    checkResetOutputs("rstMidWord");
    applyStimulus(0, 64'h003, 11);
    receiveWord(0, 0, 7, 15);
    checkOutput("rstPartial", rxWord, 64'h1E);
    pulseReset();
    checkResetOutputs("rstMidShift");
    applyStimulus(0, 64'h002, 11);
    receiveWord(0, 0, 15, 15);
    checkOutput("rstRecover", rxWord, 64'h19);
    checkOutput("rstRecoverFlags", 64'(rxFlagErr), 64'd0);
    checkOutput("rstWords", 64'(wordsOut[0]), 64'd1);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
